clk_div_ctrl: RTL
=================

# clk_div_ctrl

Runtime-programmable clock-enable scheduler for the processor core. It replaces the fixed compile-time clock division with a single-clock enable pulse whose period is set at run time. Ratio changes arrive from up to two requesters over a four-phase req/ack handshake, are arbitrated, and take effect only on a period boundary, so the core never sees a truncated or stretched enable period. It sits between the top-level clock source and the clock-enable input of the core and peripherals.

## Interface
- DIV_W, 4, width of divide-ratio fields; enable period = ratio + 1 cycles
- RESET_DIV, 1, ratio loaded at reset (period 2)

- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0  in  1  ratio-change request, port 0 (processor)
- div0  in  DIV_W  requested ratio, port 0; held stable while req0 high
- ack0  out  1  handshake acknowledge, port 0
- req1  in  1  ratio-change request, port 1 (debug/power manager)
- div1  in  DIV_W  requested ratio, port 1; held stable while req1 high
- ack1  out  1  handshake acknowledge, port 1
- clk_en  out  1  registered enable, one cycle high per period
- cur_div  out  DIV_W  ratio currently in force
- busy  out  1  high in PEND or ACK

## Operation
- Reset values: cnt = RESET_DIV, cur_div = RESET_DIV, clk_en = 0, ack0 = ack1 = 0, busy = 0, state = IDLE, pending ratio and owner cleared.
- Counter, every edge:
  - If cnt == 0: cnt <= ratio in force (new ratio on a switch edge), clk_en <= 1.
  - Otherwise: cnt <= cnt - 1, clk_en <= 0.
  - Ratio 0 gives clk_en high every cycle. Maximum ratio 2^DIV_W - 1; no wrap beyond the field width.
- FSM:
  - IDLE: arbitration is fixed priority, req0 over req1. The winner's div is latched into pend_div and its port number into owner.
    - If pend_div == cur_div, go directly to ACK.
    - Otherwise go to PEND.
  - PEND: on the edge where cnt == 0:
    - cur_div <= pend_div and cnt <= pend_div.
    - clk_en <= 1; this pulse closes the old period.
    - Go to ACK.
  - ACK: ack of the owner is high. When the owner's req is sampled low, ack goes low on that same edge and the FSM returns to IDLE.
- Requests seen while not in IDLE are ignored until the FSM returns to IDLE. A requester must hold req and div until it receives ack.
- A losing simultaneous requester is served on a later IDLE cycle.
- Changing div while req is high is illegal; the latched value is used.
- Asserting rst_n low at any point, including during PEND or ACK, immediately restores all reset values. Any pending change is discarded and no ack is issued for it.

## Timing
- After reset release, the first clk_en is registered on edge RESET_DIV+1 (edge 2 at the default).
- Request latency:
  - req sampled in IDLE gives state PEND and busy = 1 after 1 edge.
  - The switch occurs on the next cnt == 0 edge.
  - ack rises on that same edge.
  - Worst-case ack latency is 1 + (old ratio + 1) edges.
- Equal-ratio request: ack rises 1 edge after req is sampled. cnt and clk_en cadence are undisturbed.
- The first period under a new ratio is exactly new ratio + 1 cycles, measured from the switch pulse.
- ack falls on the first edge where the owner's req is sampled low. The FSM is in IDLE one cycle later, so a new request can be accepted no sooner than 1 edge after ack falls.

## Configuration
- Macro `CLK_DIV_CTRL_ARB_EN`.
- Defined: port 1 is active and fixed-priority arbitration between the two ports applies as described above.
- Undefined:
  - req1 and div1 are ignored.
  - ack1 is tied to 0.
  - owner is always port 0 and no arbitration logic is built.
  - Port 0 behaviour and timing are identical to the defined case.

## Test plan
- Reset release with RESET_DIV=1 -> clk_en high on edges 2, 4, 6, …; cur_div = 1; ack0 = ack1 = busy = 0.
- From ratio 3, at cnt = 2, req0 with div0 = 0 -> busy next edge; switch at cnt == 0 with ack0 high; thereafter clk_en high every cycle; ack0 falls on the edge req0 is seen low.
- req0 (div = 5) and req1 (div = 2) asserted together (macro defined) -> port 0 served first with cur_div = 5; after req0 drops, port 1 served and cur_div = 2; the period sequence is 6 cycles, then 3.
- req0 with div0 equal to cur_div = 4 -> ack0 one edge later; clk_en period stays 5; busy high only during ACK.
- rst_n pulsed low during PEND (ratio 7 pending from ratio 2) -> cur_div = RESET_DIV, ack0 never rises, clk_en = 0 immediately.
- Macro undefined, req1 held high with div1 = 9 -> ack1 stays 0 and cur_div is unchanged for 100 cycles.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock-enable divider with a req/ack ratio-change handshake.
// Optional macro CLK_DIV_CTRL_ARB_EN enables the second requester port and fixed-priority arbitration.
module clk_div_ctrl #(
    parameter int          DIV_W     = 4,
    parameter int unsigned RESET_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [DIV_W-1:0] div0,
    output logic             ack0,
    input  logic             req1,
    input  logic [DIV_W-1:0] div1,
    output logic             ack1,
    output logic             clk_en,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             owner_q, owner_d;
    logic             clk_en_q, clk_en_d;

    logic             req_any;
    logic [DIV_W-1:0] win_div;
    logic             win_owner;
    logic             owner_req;
    logic             cnt_zero;
    logic             switch_now;
    logic             ack0_o, ack1_o, busy_o;

`ifdef CLK_DIV_CTRL_ARB_EN
    // Fixed priority: port 0 wins whenever both requesters are raised together.
    always_comb begin
        req_any   = req0 | req1;
        win_div   = div0;
        win_owner = 1'b0;
        if (!req0 && req1) begin
            win_div   = div1;
            win_owner = 1'b1;
        end
    end

    assign owner_req = owner_q ? req1 : req0;
`else
    always_comb begin
        req_any   = req0;
        win_div   = div0;
        win_owner = 1'b0;
    end

    assign owner_req = req0;

    logic unused_port1;
    assign unused_port1 = ^{req1, div1};
`endif

    assign cnt_zero   = (cnt_q == '0);
    assign switch_now = (state_q == PEND) && cnt_zero;

    // State register: every flop of the block, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= RST_DIV;
            cur_div_q  <= RST_DIV;
            pend_div_q <= '0;
            owner_q    <= 1'b0;
            clk_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            owner_q    <= owner_d;
            clk_en_q   <= clk_en_d;
        end
    end

    // Next-state logic for the handshake FSM.
    always_comb begin
        state_d    = state_q;
        pend_div_d = pend_div_q;
        owner_d    = owner_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    pend_div_d = win_div;
                    owner_d    = win_owner;
                    state_d    = (win_div == cur_div_q) ? ACK : PEND;
                end
            end
            PEND: begin
                if (cnt_zero) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The new ratio is only adopted on a reload edge, so no period is ever cut short.
    always_comb begin
        cur_div_d = switch_now ? pend_div_q : cur_div_q;
        if (cnt_zero) begin
            cnt_d    = cur_div_d;
            clk_en_d = 1'b1;
        end else begin
            cnt_d    = cnt_q - 1'b1;
            clk_en_d = 1'b0;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        busy_o = (state_q != IDLE);
        ack0_o = (state_q == ACK) && (owner_q == 1'b0);
`ifdef CLK_DIV_CTRL_ARB_EN
        ack1_o = (state_q == ACK) && (owner_q == 1'b1);
`else
        ack1_o = 1'b0;
`endif
    end

    assign ack0    = ack0_o;
    assign ack1    = ack1_o;
    assign busy    = busy_o;
    assign clk_en  = clk_en_q;
    assign cur_div = cur_div_q;

endmodule
